// File: rtl/clock_div_pkg.sv
// Shared constants and helpers for the clock divider.
// Optional feature macro: CLOCK_DIV_ODD_HALF_EN (see clock_div.sv).
package clock_div_pkg;

  localparam int DEFAULT_DIVIDE = 4;
  localparam int DEFAULT_CNT_W  = 16;

  // Number of low cycles per period: ceil(N/2).
  function automatic int half_of(input int n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/clock_div_if.sv
// Divided-clock observation bundle: the divider drives it, consumers read it.
interface clock_div_if;

  logic clk_out;

  modport master (output clk_out);
  modport slave  (input  clk_out);

endinterface

// File: rtl/clock_div_counter.sv
// Modulo-DIVIDE phase counter for the clock divider; synchronous active-low reset.
module clock_div_counter
  import clock_div_pkg::*;
#(
  parameter int DIVIDE = DEFAULT_DIVIDE,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic             clk_in,
  input  logic             reset,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (reset) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/clock_div.sv
// Integer clock divider: clk_out = clk_in / DIVIDE, low ceil(N/2) cycles then high.
// Define CLOCK_DIV_ODD_HALF_EN to get a 50% duty cycle for odd DIVIDE.
module clock_div
  import clock_div_pkg::*;
#(
  parameter int DIVIDE = DEFAULT_DIVIDE,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic clk_in,
  input  logic reset,
  output logic clk_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIVIDE - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(half_of(DIVIDE));

  // Reject ratios the counter cannot represent (DIVIDE - 1 must fit in CNT_W bits).
  if (DIVIDE < 2 || ((DIVIDE - 1) >> CNT_W) != 0) begin : g_bad_param
    $error("clock_div: illegal DIVIDE=%0d for CNT_W=%0d", DIVIDE, CNT_W);
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             q_pos_q;
  logic             q_pos_d;

  clock_div_counter #(
    .DIVIDE (DIVIDE),
    .CNT_W  (CNT_W)
  ) u_counter (
    .clk_in (clk_in),
    .reset  (reset),
    .cnt    (cnt)
  );

  // q_pos looks at the value the counter is about to take, so the wrap to 0
  // and the falling edge of q_pos land on the same clk_in edge.
  always_comb begin
    cnt_next = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
    q_pos_d  = reset && (cnt_next >= HALF);
  end

  always_ff @(posedge clk_in) begin
    q_pos_q <= q_pos_d;
  end

`ifdef CLOCK_DIV_ODD_HALF_EN
  if ((DIVIDE % 2) == 1) begin : g_odd_half
    logic q_neg_q;
    logic q_neg_d;

    always_comb begin
      q_neg_d = reset ? q_pos_q : 1'b0;
    end

    // Half-cycle delayed copy stretches the high phase by half a clk_in period.
    always_ff @(negedge clk_in) begin
      q_neg_q <= q_neg_d;
    end

    assign clk_out = q_pos_q | q_neg_q;
  end else begin : g_even
    assign clk_out = q_pos_q;
  end
`else
  assign clk_out = q_pos_q;
`endif

endmodule

// File: tb/tb_clock_div.sv
// Self-checking bench for clock_div: four ratios (4, 2, 5, 7) share one clock and reset.
// Honours CLOCK_DIV_ODD_HALF_EN when deciding the expected odd-ratio waveform.
module tb_clock_div;

`ifdef CLOCK_DIV_ODD_HALF_EN
  localparam bit ODD_EN = 1'b1;
`else
  localparam bit ODD_EN = 1'b0;
`endif

  localparam int NDUT = 4;
  localparam int NS[NDUT] = '{4, 2, 5, 7};

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  clock_div_if if4 ();
  clock_div_if if2 ();
  clock_div_if if5 ();
  clock_div_if if7 ();

  clock_div #(.DIVIDE(4), .CNT_W(16)) u_n4 (.clk_in(clk), .reset(reset), .clk_out(if4.clk_out));
  clock_div #(.DIVIDE(2), .CNT_W(16)) u_n2 (.clk_in(clk), .reset(reset), .clk_out(if2.clk_out));
  clock_div #(.DIVIDE(5), .CNT_W(16)) u_n5 (.clk_in(clk), .reset(reset), .clk_out(if5.clk_out));
  clock_div #(.DIVIDE(7), .CNT_W(3))  u_n7 (.clk_in(clk), .reset(reset), .clk_out(if7.clk_out));

  logic [NDUT-1:0] outs;
  int unsigned     cnts[NDUT];
  assign outs = {if7.clk_out, if5.clk_out, if2.clk_out, if4.clk_out};
  always_comb begin
    cnts[0] = 32'(u_n4.u_counter.cnt);
    cnts[1] = 32'(u_n2.u_counter.cnt);
    cnts[2] = 32'(u_n5.u_counter.cnt);
    cnts[3] = 32'(u_n7.u_counter.cnt);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Waveform timing recorders, one per divider.
  longint rise_t[NDUT];
  longint per_t[NDUT];
  longint high_t[NDUT];
  for (genvar gi = 0; gi < NDUT; gi++) begin : g_meas
    initial begin
      rise_t[gi] = 0;
      per_t[gi]  = 0;
      high_t[gi] = 0;
    end
    always @(posedge outs[gi]) begin
      if (rise_t[gi] > 0) per_t[gi] = $time - rise_t[gi];
      rise_t[gi] = $time;
    end
    always @(negedge outs[gi]) begin
      if (rise_t[gi] > 0) high_t[gi] = $time - rise_t[gi];
    end
  end

  // Model: m = number of edges with reset=1 since the last reset edge.
  // Phase within a period is m mod N; high when the phase is >= ceil(N/2).
  int m = 0;
  bit qneg_m[NDUT];

  function automatic bit qpos_m(input int i, input int mm);
    return (mm % NS[i]) >= ((NS[i] + 1) / 2);
  endfunction

  function automatic bit exp_out(input int i, input int mm, input bit qn);
    if (ODD_EN && (NS[i] % 2 == 1)) return qpos_m(i, mm) | qn;
    return qpos_m(i, mm);
  endfunction

  initial begin
    for (int i = 0; i < NDUT; i++) qneg_m[i] = 1'b0;
    forever begin
      @(posedge clk);
      if (!reset) m = 0;
      else m++;
      #1;
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("out_pos_n%0d", NS[i]), int'(outs[i]), int'(exp_out(i, m, qneg_m[i])));
        chk($sformatf("cnt_n%0d", NS[i]), int'(cnts[i]), m % NS[i]);
      end
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) qneg_m[i] = reset && qpos_m(i, m);
      #1;
      for (int i = 0; i < NDUT; i++) begin
        chk($sformatf("out_neg_n%0d", NS[i]), int'(outs[i]), int'(exp_out(i, m, qneg_m[i])));
      end
    end
  end

  initial begin
    int  rises;
    logic prev;

    // Long reset: everything held at zero.
    repeat (15) @(posedge clk);
    #1;
    chk("lit_reset_cnt4", int'(cnts[0]), 0);
    chk("lit_reset_out4", int'(outs[0]), 0);
    chk("lit_reset_cnt7", int'(cnts[3]), 0);

    // Release: E0 has cnt=1 and low output for N=4; N=2 rises at E0.
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("lit_e0_out4", int'(outs[0]), 0);
    chk("lit_e0_cnt4", int'(cnts[0]), 1);
    chk("lit_e0_out2", int'(outs[1]), 1);
    @(posedge clk); #1;
    chk("lit_e1_out4", int'(outs[0]), 1);
    chk("lit_e1_out2", int'(outs[1]), 0);

    // Mid-period reset while the N=4 output is high.
    #1 reset = 1'b0;
    @(posedge clk); #1;
    chk("lit_abort_out4", int'(outs[0]), 0);
    chk("lit_abort_cnt4", int'(cnts[0]), 0);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    chk("lit_restart_e0_out4", int'(outs[0]), 0);
    @(posedge clk); #1;
    chk("lit_restart_e1_out4", int'(outs[0]), 1);

    // Long run: count N=7 rising edges over 1000 cycles.
    rises = 0;
    prev  = outs[3];
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk); #1;
      if (outs[3] && !prev) rises++;
      prev = outs[3];
    end
    n_checks++;
    if (rises < 141 || rises > 143) begin
      n_errors++;
      $display("FAIL rises_n7: got %0d, expected 142 +/- 1", rises);
    end

    chk("lit_period_n4", int'(per_t[0]), 40);
    chk("lit_high_n4", int'(high_t[0]), 20);
    chk("lit_period_n2", int'(per_t[1]), 20);
    chk("lit_high_n2", int'(high_t[1]), 10);
    chk("lit_period_n5", int'(per_t[2]), 50);
    chk("lit_high_n5", int'(high_t[2]), ODD_EN ? 25 : 20);
    chk("lit_period_n7", int'(per_t[3]), 70);
    chk("lit_high_n7", int'(high_t[3]), ODD_EN ? 35 : 30);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/clock_div.md
CLOCK_DIV -- requirements
Module: clock_div

Interface
REQ-001 Parameter DIVIDE, default 4: integer division ratio N, legal range 2..65535.
REQ-002 Parameter CNT_W, default 16: counter width, SHALL satisfy 2**CNT_W >= DIVIDE.
REQ-003 Port clk_in, input, 1 bit: sole clock; all state SHALL update on its rising edge, except REQ-015.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk_in.
REQ-005 Port clk_out, output, 1 bit: divided clock with frequency f(clk_in)/DIVIDE.
REQ-006 The module SHALL have no other ports.

Function
REQ-007 An internal counter cnt (CNT_W bits) SHALL advance on every rising edge while reset=1: cnt <= (cnt == N-1) ? 0 : cnt+1.
REQ-008 Let H = ceil(N/2) and cnt_next be the value cnt takes at the same edge; the registered output q_pos SHALL load (cnt_next >= H) on that edge.
REQ-009 clk_out period SHALL be exactly N clk_in cycles: low for H cycles, then high for N-H cycles, repeating without gaps.
REQ-010 Counter wrap N-1 -> 0 SHALL coincide with the high-to-low transition of q_pos.
REQ-011 clk_out SHALL be glitch-free: driven directly from a flop, or from the OR of two flops per REQ-015.
REQ-012 For N=2, clk_out SHALL toggle on every rising edge of clk_in after reset release, starting low.

Reset
REQ-013 With reset=0 at a rising edge, cnt SHALL be cleared to 0 and q_pos to 0, so clk_out=0 one edge later; a reset asserted mid-period SHALL abort the period immediately at that edge.
REQ-014 After release, at the first rising edge with reset=1 (E0), cnt=1 and clk_out stays 0; the first rising edge of clk_out follows edge E(H-1).

Configuration
REQ-015 With macro CLOCK_DIV_ODD_HALF_EN defined and N odd:
- A flop q_neg SHALL sample q_pos on the falling edge of clk_in.
- q_neg SHALL be cleared when reset=0 at a falling edge.
- clk_out SHALL equal q_pos OR q_neg, giving a 50% duty cycle: high N/2 cycles, low N/2 cycles.
REQ-016 With CLOCK_DIV_ODD_HALF_EN undefined, or N even, q_neg SHALL not exist and clk_out SHALL equal q_pos.

Structure
REQ-017 Package clock_div_pkg SHALL hold DEFAULT_DIVIDE (4), DEFAULT_CNT_W (16) and a function computing H from N.
REQ-018 The counter of REQ-007 SHALL be implemented in sub-module clock_div_counter (ports clk_in, reset, cnt); output logic SHALL live in clock_div.
REQ-019 An elaboration-time check SHALL fail the build if DIVIDE < 2 or 2**CNT_W < DIVIDE.

Verification
REQ-020 Release reset with N=4 and a 10 ns clk_in -> clk_out low 20 ns, high 20 ns, period 40 ns, first rise after the 2nd edge post-release.
REQ-021 Assert reset=0 for one edge while clk_out=1 mid-period -> clk_out=0 after that edge; the sequence restarts per REQ-014.
REQ-022 N=2 -> clk_out toggles every edge, period 20 ns.
REQ-023 N=5, macro undefined -> low 30 ns, high 20 ns; macro defined -> high 25 ns, low 25 ns.
REQ-024 Hold reset=0 for 15 edges -> clk_out stays 0 and cnt stays 0 throughout.
REQ-025 Run 1000 cycles with N=7 -> exactly floor(1000/7) clk_out rising edges (±1), each period 7 cycles.
